// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//   Groups the raw button inputs and the conditioned outputs of the button
//   conditioner into one bundle.
//
//   Signals (all N_BTN wide, one bit per button channel):
//     i_nBtn  - raw buttons, active-low (0 = pressed), asynchronous to the clock
//     o_Pulse - one-clock high pulse per accepted press
//     o_Level - debounced pressed level (1 = pressed)
//     o_Long  - one-clock high pulse when a press has been held long enough
//
//   Modports:
//     master - the side that drives the raw buttons and consumes the outputs
//     slave  - the conditioner itself
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] i_nBtn;
  logic [N_BTN-1:0] o_Pulse;
  logic [N_BTN-1:0] o_Level;
  logic [N_BTN-1:0] o_Long;

  modport master (
    output i_nBtn,
    input  o_Pulse,
    input  o_Level,
    input  o_Long
  );

  modport slave (
    input  i_nBtn,
    output o_Pulse,
    output o_Level,
    output o_Long
  );
endinterface

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Input stage for the stopwatch core. Each raw, active-low, bouncing push
//   button is synchronised, debounced and turned into a clean one-clock press
//   pulse, a debounced pressed level and a one-shot long-press pulse.
//   Channels are independent copies of the same logic.
//
//   Ports:
//     Clk - system clock, rising edge
//     Rst - synchronous, active-high reset
//     btn - button_conditioner_if.slave bundle (i_nBtn in; o_Pulse, o_Level,
//           o_Long out; all registered)
//
//   Parameters:
//     N_BTN       - number of button channels
//     DEB_CYCLES  - stable cycles needed to accept a press or a release (>= 2)
//     LONG_CYCLES - cycles held before the long-press pulse fires (>= 1)
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN       = 3,
  parameter int DEB_CYCLES  = 500_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic                Clk,
  input  logic                Rst,
  button_conditioner_if.slave btn
);

  // Counters only ever need to reach PARAM-1.
  localparam int DCNT_W = $clog2(DEB_CYCLES);
  localparam int HCNT_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;
  logic [N_BTN-1:0] pulse_s;
  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] long_s;

  // Two-flop synchroniser for the asynchronous raw buttons; idles at released.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_q <= {N_BTN{1'b1}};
      s2_q <= {N_BTN{1'b1}};
    end else begin
      s1_q <= btn.i_nBtn;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              long_done_q, long_done_d;
    logic              pulse_q, pulse_d;
    logic              level_q, level_d;
    logic              long_q, long_d;
    logic              pressed_s;

    // The synchronised button is active-low.
    assign pressed_s = ~s2_q[g];

    // Next-state and output decode for one channel's debounce FSM.
    always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_done_d = long_done_q;
      pulse_d     = 1'b0;
      level_d     = level_q;
      long_d      = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pressed_s) begin
            state_d = ST_PRESS_WAIT;
            dcnt_d  = {DCNT_W{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_PRESS_WAIT: begin
          if (!pressed_s) begin
            // Glitch: drop back silently.
            state_d = ST_IDLE;
          end else if (dcnt_q == DCNT_LAST) begin
            state_d     = ST_HELD;
            pulse_d     = 1'b1;
            level_d     = 1'b1;
            hcnt_d      = {HCNT_W{1'b0}};
            long_done_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
          end
        end

        ST_HELD: begin
          if (!pressed_s) begin
            state_d = ST_RELEASE_WAIT;
            dcnt_d  = {DCNT_W{1'b0}};
          end else if (hcnt_q == HCNT_LAST) begin
            // hcnt saturates here; the done flag keeps o_Long one-shot.
            if (!long_done_q) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
            end else begin
              long_d = 1'b0;
            end
          end else begin
            hcnt_d = hcnt_q + HCNT_ONE;
          end
        end

        ST_RELEASE_WAIT: begin
          if (pressed_s) begin
            // Release bounce: resume the same press, hcnt and done flag kept.
            state_d = ST_HELD;
          end else if (dcnt_q == DCNT_LAST) begin
            state_d = ST_IDLE;
            level_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + DCNT_ONE;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          dcnt_d      = {DCNT_W{1'b0}};
          hcnt_d      = {HCNT_W{1'b0}};
          long_done_d = 1'b0;
          level_d     = 1'b0;
        end
      endcase
    end

    // State, counters and registered outputs for one channel.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        state_q     <= ST_IDLE;
        dcnt_q      <= {DCNT_W{1'b0}};
        hcnt_q      <= {HCNT_W{1'b0}};
        long_done_q <= 1'b0;
        pulse_q     <= 1'b0;
        level_q     <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        hcnt_q      <= hcnt_d;
        long_done_q <= long_done_d;
        pulse_q     <= pulse_d;
        level_q     <= level_d;
        long_q      <= long_d;
      end
    end

    assign pulse_s[g] = pulse_q;
    assign level_s[g] = level_q;
    assign long_s[g]  = long_q;
  end

  assign btn.o_Pulse = pulse_s;
  assign btn.o_Level = level_s;
  assign btn.o_Long  = long_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEB_CYCLES=4, LONG_CYCLES=10).
// Expected outputs after each clock edge are pushed to a scoreboard queue
// while stimulus is set up, then popped and compared one per edge.
module tb_button_conditioner;
  localparam int N    = 3;
  localparam int DEB  = 4;
  localparam int LONG = 10;

  logic Clk = 1'b0;
  logic Rst;

  button_conditioner_if #(.N_BTN(N)) bif ();

  button_conditioner #(
    .N_BTN      (N),
    .DEB_CYCLES (DEB),
    .LONG_CYCLES(LONG)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .btn(bif)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] p;
    logic [2:0] l;
    logic [2:0] g;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Queue n edges' worth of expected outputs.
  task automatic push_exp(input int n, input logic [2:0] p, input logic [2:0] l,
                          input logic [2:0] g);
    exp_t e;
    e.p = p;
    e.l = l;
    e.g = g;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  // Advance one edge per queued entry and compare after each edge.
  task automatic drain(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      @(posedge Clk);
      #1;
      e = sb_q.pop_front();
      total++;
      assert (bif.o_Pulse === e.p) else begin
        bad++;
        $error("FAIL %s pulse cyc=%0d observed=%b expected=%b", tag, cyc, bif.o_Pulse, e.p);
      end
      total++;
      assert (bif.o_Level === e.l) else begin
        bad++;
        $error("FAIL %s level cyc=%0d observed=%b expected=%b", tag, cyc, bif.o_Level, e.l);
      end
      total++;
      assert (bif.o_Long === e.g) else begin
        bad++;
        $error("FAIL %s long cyc=%0d observed=%b expected=%b", tag, cyc, bif.o_Long, e.g);
      end
      cyc++;
    end
  endtask

  initial begin
    // Reset held with all buttons pressed: outputs stay 0.
    Rst = 1'b1;
    bif.i_nBtn = 3'b000;
    push_exp(3, 3'b000, 3'b000, 3'b000);
    drain("reset");

    // Release reset: all three channels pulse together 6 edges later.
    Rst = 1'b0;
    push_exp(6, 3'b000, 3'b000, 3'b000);
    push_exp(1, 3'b111, 3'b111, 3'b000);
    push_exp(1, 3'b000, 3'b111, 3'b000);
    drain("rst_release");
    bif.i_nBtn = 3'b111;
    push_exp(6, 3'b000, 3'b111, 3'b000);
    push_exp(3, 3'b000, 3'b000, 3'b000);
    drain("rst_release_up");

    // Clean press on bit0, release sampled 9 edges later.
    bif.i_nBtn = 3'b110;
    push_exp(6, 3'b000, 3'b000, 3'b000);
    push_exp(1, 3'b001, 3'b001, 3'b000);
    push_exp(2, 3'b000, 3'b001, 3'b000);
    drain("clean_press");
    bif.i_nBtn = 3'b111;
    push_exp(6, 3'b000, 3'b001, 3'b000);
    push_exp(3, 3'b000, 3'b000, 3'b000);
    drain("clean_release");

    // Bounce on bit1: 0,1,0,1 one cycle each, then held low.
    bif.i_nBtn = 3'b101; push_exp(1, 3'b000, 3'b000, 3'b000); drain("bounce");
    bif.i_nBtn = 3'b111; push_exp(1, 3'b000, 3'b000, 3'b000); drain("bounce");
    bif.i_nBtn = 3'b101; push_exp(1, 3'b000, 3'b000, 3'b000); drain("bounce");
    bif.i_nBtn = 3'b111; push_exp(1, 3'b000, 3'b000, 3'b000); drain("bounce");
    bif.i_nBtn = 3'b101;
    push_exp(6, 3'b000, 3'b000, 3'b000);
    push_exp(1, 3'b010, 3'b010, 3'b000);
    push_exp(1, 3'b000, 3'b010, 3'b000);
    drain("bounce_settle");
    bif.i_nBtn = 3'b111;
    push_exp(6, 3'b000, 3'b010, 3'b000);
    push_exp(3, 3'b000, 3'b000, 3'b000);
    drain("bounce_release");

    // Short glitch on bit2: low for 3 cycles only.
    bif.i_nBtn = 3'b011;
    push_exp(3, 3'b000, 3'b000, 3'b000);
    drain("glitch_low");
    bif.i_nBtn = 3'b111;
    push_exp(10, 3'b000, 3'b000, 3'b000);
    drain("glitch_high");

    // Long press on bit0 for 30 cycles: pulse at edge 6, long at edge 16 only.
    bif.i_nBtn = 3'b110;
    push_exp(6, 3'b000, 3'b000, 3'b000);
    push_exp(1, 3'b001, 3'b001, 3'b000);
    push_exp(9, 3'b000, 3'b001, 3'b000);
    push_exp(1, 3'b000, 3'b001, 3'b001);
    push_exp(13, 3'b000, 3'b001, 3'b000);
    drain("long_press");
    // Release bounce of 2 high cycles: level stays, no new pulse, no new long.
    bif.i_nBtn = 3'b111;
    push_exp(2, 3'b000, 3'b001, 3'b000);
    drain("long_rel_bounce");
    bif.i_nBtn = 3'b110;
    push_exp(12, 3'b000, 3'b001, 3'b000);
    drain("long_rehold");
    bif.i_nBtn = 3'b111;
    push_exp(6, 3'b000, 3'b001, 3'b000);
    push_exp(3, 3'b000, 3'b000, 3'b000);
    drain("long_release");

    // Reset one cycle after bit1 level rises, button kept low throughout.
    bif.i_nBtn = 3'b101;
    push_exp(6, 3'b000, 3'b000, 3'b000);
    push_exp(1, 3'b010, 3'b010, 3'b000);
    drain("midrst_press");
    Rst = 1'b1;
    push_exp(1, 3'b000, 3'b000, 3'b000);
    drain("midrst_assert");
    Rst = 1'b0;
    push_exp(6, 3'b000, 3'b000, 3'b000);
    push_exp(1, 3'b010, 3'b010, 3'b000);
    push_exp(1, 3'b000, 3'b010, 3'b000);
    drain("midrst_repress");
    bif.i_nBtn = 3'b111;
    push_exp(6, 3'b000, 3'b010, 3'b000);
    push_exp(2, 3'b000, 3'b000, 3'b000);
    drain("midrst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
